// File: rtl/incr_repeat_ctrl.sv
// Push-switch increment controller: synchronise and debounce SW0, then drive a
// 4-digit BCD counter with auto-repeat and registered 7-segment outputs.
module incr_repeat_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned HOLD_CYC     = 8,
    parameter int unsigned REPEAT_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SW0,
    output logic [27:0] HEX_arr,
    output logic [15:0] count_bcd,
    output logic        inc_pulse,
    output logic [2:0]  state
);

    localparam int unsigned MaxDh  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
    localparam int unsigned MaxCyc = (MaxDh > REPEAT_CYC) ? MaxDh : REPEAT_CYC;
    localparam int unsigned TimerW = (MaxCyc > 2) ? $clog2(MaxCyc) : 1;

    localparam logic [TimerW-1:0] DbLast     = TimerW'(DEBOUNCE_CYC - 1);
    localparam logic [TimerW-1:0] HoldLast   = TimerW'(HOLD_CYC - 1);
    localparam logic [TimerW-1:0] RepeatLast = TimerW'(REPEAT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDbOn   = 3'd1,
        StHold   = 3'd2,
        StRepeat = 3'd3,
        StDbOff  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               sw_meta_q, sw_s_q;
    logic [15:0]        count_q, count_d;
    logic               inc_q, inc_d;
    logic [27:0]        hex_q;

    // Ripple-carry BCD increment; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-low segments, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        inc_d   = 1'b0;

        // Release is checked before any expiry so a simultaneous release never increments.
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (sw_s_q) begin
                    state_d = StDbOn;
                end
            end
            StDbOn: begin
                if (!sw_s_q) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timer_q == DbLast) begin
                    state_d = StHold;
                    timer_d = '0;
                    inc_d   = 1'b1;
                end
            end
            StHold: begin
                if (!sw_s_q) begin
                    state_d = StDbOff;
                    timer_d = '0;
                end else if (timer_q == HoldLast) begin
                    state_d = StRepeat;
                    timer_d = '0;
                    inc_d   = 1'b1;
                end
            end
            StRepeat: begin
                if (!sw_s_q) begin
                    state_d = StDbOff;
                    timer_d = '0;
                end else if (timer_q == RepeatLast) begin
                    timer_d = '0;
                    inc_d   = 1'b1;
                end
            end
            StDbOff: begin
                if (sw_s_q) begin
                    timer_d = '0;
                end else if (timer_q == DbLast) begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase

        count_d = inc_d ? bcd_inc(count_q) : count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q <= 1'b0;
            sw_s_q    <= 1'b0;
            state_q   <= StIdle;
            timer_q   <= '0;
            count_q   <= 16'h0000;
            inc_q     <= 1'b0;
            hex_q     <= {4{7'b1000000}};
        end else begin
            sw_meta_q <= SW0;
            sw_s_q    <= sw_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            inc_q     <= inc_d;
            hex_q     <= {seg7(count_q[15:12]), seg7(count_q[11:8]),
                          seg7(count_q[7:4]), seg7(count_q[3:0])};
        end
    end

    assign HEX_arr   = hex_q;
    assign count_bcd = count_q;
    assign inc_pulse = inc_q;
    assign state     = state_q;

endmodule

// File: tb/tb_incr_repeat_ctrl.sv
// Directed bench for incr_repeat_ctrl: debounce, auto-repeat, BCD carry/wrap,
// segment encoding and asynchronous reset behaviour.
module tb_incr_repeat_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SW0 = 1'b0;
    logic [27:0] HEX_arr;
    logic [15:0] count_bcd;
    logic        inc_pulse;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    localparam logic [27:0] HexZero = 28'h8102040;

    incr_repeat_ctrl #(
        .DEBOUNCE_CYC(4),
        .HOLD_CYC    (8),
        .REPEAT_CYC  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SW0      (SW0),
        .HEX_arr  (HEX_arr),
        .count_bcd(count_bcd),
        .inc_pulse(inc_pulse),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        SW0 = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        logic [6:0] tbl [0:9];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    function automatic logic [15:0] bcd_of(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [27:0] hex_of(input int n);
        return {seg_ref((n / 1000) % 10), seg_ref((n / 100) % 10),
                seg_ref((n / 10) % 10), seg_ref(n % 10)};
    endfunction

    task automatic test_reset();
        int first;
        first = -1;
        SW0 = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want 0000", count_bcd); end
        checks++; if (HEX_arr !== HexZero) begin errors++; $display("FAIL reset_hex got %h want %h", HEX_arr, HexZero); end
        checks++; if (inc_pulse !== 1'b0) begin errors++; $display("FAIL reset_inc got %b want 0", inc_pulse); end
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (inc_pulse === 1'b1 && first < 0) first = i;
        end
        checks++; if (first != 6) begin errors++; $display("FAIL reset_release_latency got %0d want 6", first); end
        SW0 = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_single_press();
        int pulses, first, hex_at;
        logic [2:0] trace [$];
        logic [2:0] exp_trace [$];
        do_reset();
        pulses = 0; first = -1; hex_at = -1;
        trace.push_back(state);
        exp_trace = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        for (int i = 0; i < 30; i++) begin
            SW0 = (i < 10);
            tick();
            if (inc_pulse === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (hex_at < 0 && HEX_arr[6:0] !== 7'b1000000) hex_at = i;
            if (state !== trace[$]) trace.push_back(state);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
        checks++; if (first != 6) begin errors++; $display("FAIL single_inc_edge got %0d want 6", first); end
        checks++; if (hex_at != 7) begin errors++; $display("FAIL single_hex_edge got %0d want 7", hex_at); end
        checks++; if (count_bcd !== 16'h0001) begin errors++; $display("FAIL single_count got %h want 0001", count_bcd); end
        checks++; if (HEX_arr[6:0] !== 7'b1111001) begin errors++; $display("FAIL single_hex0 got %b want 1111001", HEX_arr[6:0]); end
        checks++; if (trace != exp_trace) begin errors++; $display("FAIL single_state_trace got %p want %p", trace, exp_trace); end
    endtask

    task automatic test_glitch();
        logic pat [0:10];
        int pulses;
        logic saw_dbon;
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        pulses = 0; saw_dbon = 1'b0;
        for (int i = 0; i < 31; i++) begin
            SW0 = (i < 11) ? pat[i] : 1'b0;
            tick();
            if (inc_pulse === 1'b1) pulses++;
            if (state === 3'd1) saw_dbon = 1'b1;
        end
        checks++; if (saw_dbon !== 1'b1) begin errors++; $display("FAIL glitch_dbon_seen got %b want 1", saw_dbon); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL glitch_count got %h want 0000", count_bcd); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL glitch_state got %0d want 0", state); end
    endtask

    task automatic test_auto_repeat();
        int edges [$];
        int exp_edges [$];
        do_reset();
        exp_edges = '{6, 14, 18, 22, 26, 30, 34, 38, 42};
        for (int i = 0; i < 60; i++) begin
            SW0 = (i < 42);
            tick();
            if (inc_pulse === 1'b1) edges.push_back(i);
        end
        checks++; if (edges != exp_edges) begin errors++; $display("FAIL repeat_edges got %p want %p", edges, exp_edges); end
        checks++; if (count_bcd !== 16'h0009) begin errors++; $display("FAIL repeat_count got %h want 0009", count_bcd); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL repeat_final_state got %0d want 0", state); end
    endtask

    task automatic test_carry_wrap();
        int n, pend_n;
        do_reset();
        n = 0; pend_n = -1;
        SW0 = 1'b1;
        for (int i = 0; i < 41000 && n < 9999; i++) begin
            tick();
            if (pend_n >= 0) begin
                checks++;
                if (HEX_arr !== hex_of(pend_n)) begin
                    errors++; $display("FAIL carry_hex_%0d got %h want %h", pend_n, HEX_arr, hex_of(pend_n));
                end
                pend_n = -1;
            end
            if (inc_pulse === 1'b1) begin
                n++;
                if (n == 1 || n == 9 || n == 10 || n == 99 || n == 100 || n == 999 ||
                    n == 1000 || n == 9999) begin
                    checks++;
                    if (count_bcd !== bcd_of(n)) begin
                        errors++; $display("FAIL carry_count_%0d got %h want %h", n, count_bcd, bcd_of(n));
                    end
                    pend_n = n;
                end
            end
        end
        SW0 = 1'b0;
        checks++; if (n != 9999) begin errors++; $display("FAIL carry_reach_9999 got %0d want 9999", n); end
        tick();
        checks++; if (HEX_arr !== hex_of(9999)) begin errors++; $display("FAIL carry_hex_9999 got %h want %h", HEX_arr, hex_of(9999)); end
        repeat (20) tick();
        checks++; if (count_bcd !== 16'h9999) begin errors++; $display("FAIL carry_hold_9999 got %h want 9999", count_bcd); end
        for (int i = 0; i < 30; i++) begin
            SW0 = (i < 10);
            tick();
        end
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h want 0000", count_bcd); end
        checks++; if (HEX_arr !== HexZero) begin errors++; $display("FAIL wrap_hex got %h want %h", HEX_arr, HexZero); end
    endtask

    task automatic test_mid_reset();
        logic reached;
        do_reset();
        reached = 1'b0;
        SW0 = 1'b1;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (state === 3'd3) reached = 1'b1;
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL midrst_reach_repeat got %b want 1", reached); end
        #1 rst = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL midrst_state got %0d want 0", state); end
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL midrst_count got %h want 0000", count_bcd); end
        checks++; if (HEX_arr !== HexZero) begin errors++; $display("FAIL midrst_hex got %h want %h", HEX_arr, HexZero); end
        checks++; if (inc_pulse !== 1'b0) begin errors++; $display("FAIL midrst_inc got %b want 0", inc_pulse); end
        SW0 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL midrst_idle_after got %0d want 0", state); end
    endtask

    task automatic test_release_on_expiry();
        int pulses;
        logic [2:0] st13, st14;
        do_reset();
        pulses = 0; st13 = 3'd7; st14 = 3'd7;
        for (int i = 0; i < 30; i++) begin
            SW0 = (i < 12);
            tick();
            if (inc_pulse === 1'b1) pulses++;
            if (i == 13) st13 = state;
            if (i == 14) st14 = state;
        end
        checks++; if (st13 !== 3'd2) begin errors++; $display("FAIL expiry_pre_state got %0d want 2", st13); end
        checks++; if (st14 !== 3'd4) begin errors++; $display("FAIL expiry_state got %0d want 4", st14); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL expiry_pulses got %0d want 1", pulses); end
        checks++; if (count_bcd !== 16'h0001) begin errors++; $display("FAIL expiry_count got %h want 0001", count_bcd); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_auto_repeat();
        test_mid_reset();
        test_release_on_expiry();
        test_carry_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
